// File: rtl/randlog_array_if.sv
// rtl/randlog_array_if.sv - control, seed and result stream bundle for randlog_array
interface randlog_array_if #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int F  = 16
);
    localparam int OUT_W = $clog2(W + 1) + F;

    logic                  seed_load;
    logic [CH*W-1:0]       seed;
    logic                  en;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*OUT_W-1:0]   out_data;
    logic [W-1:0]          state_dbg;
    logic [31:0]           sample_cnt;

    modport slave (
        input  seed_load, seed, en, out_ready,
        output out_valid, out_data, state_dbg, sample_cnt
    );

    modport master (
        output seed_load, seed, en, out_ready,
        input  out_valid, out_data, state_dbg, sample_cnt
    );
endinterface

// File: rtl/randlog_array.sv
// rtl/randlog_array.sv - CH-channel LFSR sampler producing -log2(u/2^W) in fixed point
module randlog_array #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int L  = 6,
    parameter int R  = 8,
    parameter int F  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    randlog_array_if.slave bus
);
    localparam int OUT_W = $clog2(W + 1) + F;
    localparam int LZW   = $clog2(W);
    localparam logic [W-1:0] TAPS = (W == 32) ? W'(32'h8020_0003) : W'(16'hB400);

    function automatic logic [F:0] lut_entry(input int k);
        real v;
        v = $ln(1.0 + real'(k) / (2.0 ** L)) / $ln(2.0) * (2.0 ** F);
        return (F+1)'($rtoi(v + 0.5));
    endfunction

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    logic [F:0] lut [2**L+1];
    for (genvar k = 0; k <= 2**L; k++) begin : g_lut
        assign lut[k] = lut_entry(k);
    end

    logic [W-1:0]     lfsr  [CH];
    logic [W-1:0]     u1    [CH];
    logic [LZW-1:0]   lz2   [CH];
    logic [R-1:0]     r2    [CH];
    logic [F:0]       ll2   [CH];
    logic [F:0]       lr2   [CH];
    logic [LZW-1:0]   lz3   [CH];
    logic [F:0]       frac3 [CH];
    logic [OUT_W-1:0] res4  [CH];
    logic             v1, v2, v3, v4;
    logic [31:0]      cnt;

    logic [LZW-1:0]   lz1   [CH];
    logic [L+R-1:0]   ir1   [CH];
    logic [L:0]       li1   [CH];
    logic [L:0]       ri1   [CH];
    logic [F+R:0]     prod2 [CH];
    logic [F:0]       frac2 [CH];
    logic [OUT_W-1:0] res3  [CH];

    logic stall, adv, take, hs;
    assign stall = v4 && !bus.out_ready;
    assign adv   = !stall;
    assign take  = bus.en && adv && !bus.seed_load;
    assign hs    = v4 && bus.out_ready;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            // ascending scan: the last hit is the highest set bit
            lz1[c] = LZW'(W - 1);
            for (int b = 0; b < W; b++) begin
                if (u1[c][b]) lz1[c] = LZW'(W - 1 - b);
            end
            // drop the normalised leading one, keep index and interpolation bits
            ir1[c]   = (L+R)'((u1[c] << lz1[c]) >> (W - 1 - L - R));
            li1[c]   = {1'b0, ir1[c][L+R-1 -: L]};
            ri1[c]   = li1[c] + (L+1)'(1);
            prod2[c] = {{R{1'b0}}, lr2[c] - ll2[c]} * {{(F+1){1'b0}}, r2[c]};
            frac2[c] = ll2[c] + (F+1)'(prod2[c] >> R);
            res3[c]  = ((OUT_W'(lz3[c]) + OUT_W'(1)) << F) - OUT_W'(frac3[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) lfsr[c] <= W'(1);
            {v1, v2, v3, v4} <= '0;
            cnt <= '0;
        end else if (bus.seed_load) begin
            for (int c = 0; c < CH; c++)
                lfsr[c] <= (bus.seed[c*W +: W] == '0) ? W'(1) : bus.seed[c*W +: W];
            {v1, v2, v3, v4} <= '0;
            cnt <= '0;
        end else begin
            if (hs) cnt <= cnt + 32'd1;
            if (take) begin
                for (int c = 0; c < CH; c++) lfsr[c] <= lfsr_step(lfsr[c]);
            end
            if (adv) begin
                v1 <= take;
                v2 <= v1;
                v3 <= v2;
                v4 <= v3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                u1[c]    <= '0;
                lz2[c]   <= '0;
                r2[c]    <= '0;
                ll2[c]   <= '0;
                lr2[c]   <= '0;
                lz3[c]   <= '0;
                frac3[c] <= '0;
                res4[c]  <= '0;
            end
        end else if (adv) begin
            for (int c = 0; c < CH; c++) begin
                u1[c]    <= lfsr[c];
                lz2[c]   <= lz1[c];
                r2[c]    <= ir1[c][R-1:0];
                ll2[c]   <= lut[li1[c]];
                lr2[c]   <= lut[ri1[c]];
                lz3[c]   <= lz2[c];
                frac3[c] <= frac2[c];
                res4[c]  <= res3[c];
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < CH; c++) bus.out_data[c*OUT_W +: OUT_W] = res4[c];
    end

    assign bus.out_valid  = v4;
    assign bus.state_dbg  = lfsr[0];
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_randlog_array.sv
// tb/tb_randlog_array.sv - scoreboard bench for randlog_array
module tb_randlog_array;
    localparam int CH = 4;
    localparam int W  = 16;
    localparam int L  = 6;
    localparam int R  = 8;
    localparam int F  = 16;
    localparam int OUT_W = $clog2(W + 1) + F;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    randlog_array_if #(.CH(CH), .W(W), .F(F)) bus ();
    randlog_array #(.CH(CH), .W(W), .L(L), .R(R), .F(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int lut_m [2**L+1];
    logic [W-1:0] m_st [CH];
    int m_cnt;
    logic [CH*OUT_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] step_m(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [OUT_W-1:0] model(input logic [W-1:0] u);
        int lz;
        longint n, m, i, r, ll, lr, frac, res;
        lz = 0;
        while (lz < W - 1 && u[W-1-lz] == 1'b0) lz++;
        n = (longint'(u) << lz) & ((longint'(1) << W) - 1);
        m = n & ((longint'(1) << (W - 1)) - 1);
        i = m >> (W - 1 - L);
        r = (m >> (W - 1 - L - R)) & ((longint'(1) << R) - 1);
        ll = lut_m[i];
        lr = lut_m[i+1];
        frac = ll + (((lr - ll) * r) >> R);
        res = (longint'(lz + 1) << F) - frac;
        return OUT_W'(res);
    endfunction

    function automatic logic [OUT_W-1:0] ch(input int c);
        return bus.out_data[c*OUT_W +: OUT_W];
    endfunction

    task automatic tick();
        logic hs, stl;
        logic [CH*OUT_W-1:0] e;
        hs  = bus.out_valid && bus.out_ready;
        stl = bus.out_valid && !bus.out_ready;
        if (bus.seed_load) begin
            exp_q.delete();
            m_cnt = 0;
            for (int c = 0; c < CH; c++)
                m_st[c] = (bus.seed[c*W +: W] == '0) ? W'(1) : bus.seed[c*W +: W];
        end else begin
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < CH; c++)
                        check($sformatf("data_ch%0d", c), 64'(ch(c)), 64'(e[c*OUT_W +: OUT_W]));
                end
                m_cnt++;
            end
            if (bus.en && !stl) begin
                for (int c = 0; c < CH; c++) begin
                    e[c*OUT_W +: OUT_W] = model(m_st[c]);
                    m_st[c] = step_m(m_st[c]);
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load_seeds(input logic [CH*W-1:0] s);
        bus.seed = s;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
    endtask

    initial begin
        logic [CH*OUT_W-1:0] snap;
        int period;
        logic zero_seen;

        for (int k = 0; k <= 2**L; k++)
            lut_m[k] = int'($floor($ln(1.0 + real'(k) / (2.0 ** L)) / $ln(2.0) * (2.0 ** F) + 0.5));
        rst_n = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed = '0;
        bus.en = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < CH; c++) m_st[c] = W'(1);
        m_cnt = 0;
        repeat (2) @(negedge clk);

        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_dbg", 64'(bus.state_dbg), 64'd1);
        check("rst_cnt", 64'(bus.sample_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // known-value seeds on the four channels
        bus.out_ready = 1'b1;
        load_seeds({16'hFFFF, 16'hC000, 16'h8000, 16'h0001});
        check("seed_dbg", 64'(bus.state_dbg), 64'd1);
        bus.en = 1'b1;
        tick();
        check("dbg_step", 64'(bus.state_dbg), 64'hB400);
        tick();
        tick();
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("seed_0001", 64'(ch(0)), 64'h100000);
        check("seed_8000", 64'(ch(1)), 64'h010000);
        check("seed_c000", 64'(ch(2)), 64'h006A40);
        check("seed_ffff_le4", 64'(ch(3) <= 21'd4), 64'd1);
        run(20);

        // 5-cycle backpressure: output frozen, scoreboard keeps order
        bus.out_ready = 1'b0;
        snap = bus.out_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_data", 64'(bus.out_data == snap), 64'd1);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        run(20);
        check("cnt_after_stall", 64'(bus.sample_cnt), 64'(m_cnt));

        // seed_load coincident with a handshake, zero seeds behave as 1
        check("hs_pending", 64'(bus.out_valid), 64'd1);
        load_seeds('0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_cnt", 64'(bus.sample_cnt), 64'd0);
        check("zero_seed_dbg", 64'(bus.state_dbg), 64'd1);
        period = 0;
        zero_seen = 1'b0;
        for (int k = 1; k <= 66000; k++) begin
            tick();
            if (period == 0 && bus.state_dbg == 16'd1) period = k;
            if (bus.state_dbg == '0) zero_seen = 1'b1;
        end
        check("lfsr_period", 64'(period), 64'd65535);
        check("dbg_never_zero", 64'(zero_seen), 64'd0);

        // random backpressure and request gaps
        load_seeds({$urandom, $urandom});
        for (int k = 0; k < 1000; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.en = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("cnt_random", 64'(bus.sample_cnt), 64'(m_cnt));

        // seed_load during a stall
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        run(6);
        bus.out_ready = 1'b0;
        tick();
        check("stall_before_load", 64'(bus.out_valid), 64'd1);
        load_seeds(64'h1234_5678_9ABC_DEF0);
        check("load_stall_valid", 64'(bus.out_valid), 64'd0);
        check("load_stall_dbg", 64'(bus.state_dbg), 64'hDEF0);
        check("load_stall_cnt", 64'(bus.sample_cnt), 64'd0);
        bus.out_ready = 1'b1;
        run(10);

        // asynchronous reset pulse mid-stream
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_cnt", 64'(bus.sample_cnt), 64'd0);
        check("arst_data", 64'(bus.out_data), 64'd0);
        check("arst_dbg", 64'(bus.state_dbg), 64'd1);
        #2 rst_n = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        for (int c = 0; c < CH; c++) m_st[c] = W'(1);
        run(12);

        bus.en = 1'b0;
        run(8);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(bus.out_valid), 64'd0);
        check("cnt_final", 64'(bus.sample_cnt), 64'(m_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
